// File: rtl/gen_scheduler.sv
// Generation scheduler: paces generation/seed operations off VGA frame ticks and
// swaps the displayed buffer only on a frame tick once the engine has finished.
module gen_scheduler #(
    parameter int LOG_MAX_SPEED = 5,
    parameter int LOG_NUM_SEED  = 3,
    parameter int GEN_CNT_W     = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     vsync_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     step_in,
    input  logic                     seed_load_in,
    input  logic [LOG_NUM_SEED-1:0]  seed_sel_in,
    input  logic                     engine_done_in,
    output logic                     gen_start_out,
    output logic                     seed_start_out,
    output logic [LOG_NUM_SEED-1:0]  seed_sel_out,
    output logic                     buf_sel_out,
    output logic [GEN_CNT_W-1:0]     gen_count_out,
    output logic                     busy_out
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GEN       = 2'd1,
        ST_SEED      = 2'd2,
        ST_PEND_SWAP = 2'd3
    } state_t;

    localparam logic [LOG_MAX_SPEED:0] MAX_SPEED = {1'b1, {LOG_MAX_SPEED{1'b0}}};
    localparam logic [LOG_MAX_SPEED:0] ONE_F     = {{LOG_MAX_SPEED{1'b0}}, 1'b1};
    localparam logic [GEN_CNT_W-1:0]   ONE_G     = {{(GEN_CNT_W-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_vsync_prev;
    logic [LOG_MAX_SPEED-1:0] r_frame_cnt;
    logic                     r_seed_pend;
    logic [LOG_NUM_SEED-1:0]  r_pend_sel;
    logic                     r_op_seed;
    logic                     r_gen_start;
    logic                     r_seed_start;
    logic [LOG_NUM_SEED-1:0]  r_seed_sel;
    logic                     r_buf_sel;
    logic [GEN_CNT_W-1:0]     r_gen_count;
    logic                     r_busy;

    logic                     w_tick;
    logic [LOG_MAX_SPEED:0]   w_interval;
    logic [LOG_MAX_SPEED:0]   w_frame_next;
    logic                     w_timer_hit;
    logic                     w_start_gen;
    logic                     w_start_seed;
    logic                     w_swap;
    logic                     w_busy_next;
    logic                     w_buf_next;
    logic [GEN_CNT_W-1:0]     w_gen_count_next;
    logic [LOG_NUM_SEED-1:0]  w_seed_sel_next;

    assign w_tick       = r_vsync_prev & ~vsync_in;
    assign w_interval   = MAX_SPEED - {1'b0, speed_in};
    assign w_frame_next = {1'b0, r_frame_cnt} + ONE_F;
    // >= rather than == so that raising the speed mid-interval never stalls the timer
    assign w_timer_hit  = w_tick && (speed_in != '0) && (w_frame_next >= w_interval);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and start/swap decisions; a pending seed load outranks every IDLE trigger
    always_comb begin
        w_next_state = r_state;
        w_start_gen  = 1'b0;
        w_start_seed = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (seed_load_in || r_seed_pend) begin
                    w_start_seed = 1'b1;
                    w_next_state = ST_SEED;
                end else if ((step_in && (speed_in == '0)) || w_timer_hit) begin
                    w_start_gen  = 1'b1;
                    w_next_state = ST_GEN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GEN, ST_SEED: begin
                if (engine_done_in) begin
                    w_next_state = ST_PEND_SWAP;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_PEND_SWAP: begin
                if (w_tick) begin
                    w_swap       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_PEND_SWAP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_busy_next = (w_next_state != ST_IDLE);
        if (w_swap) begin
            w_buf_next = ~r_buf_sel;
            if (r_op_seed) begin
                w_gen_count_next = '0;
            end else begin
                w_gen_count_next = r_gen_count + ONE_G;
            end
        end else begin
            w_buf_next       = r_buf_sel;
            w_gen_count_next = r_gen_count;
        end
        if (w_start_seed) begin
            if (seed_load_in) begin
                w_seed_sel_next = seed_sel_in;
            end else begin
                w_seed_sel_next = r_pend_sel;
            end
        end else begin
            w_seed_sel_next = r_seed_sel;
        end
    end

    // Output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_gen_start  <= 1'b0;
            r_seed_start <= 1'b0;
            r_busy       <= 1'b0;
            r_buf_sel    <= 1'b0;
            r_gen_count  <= '0;
            r_seed_sel   <= '0;
        end else begin
            r_gen_start  <= w_start_gen;
            r_seed_start <= w_start_seed;
            r_busy       <= w_busy_next;
            r_buf_sel    <= w_buf_next;
            r_gen_count  <= w_gen_count_next;
            r_seed_sel   <= w_seed_sel_next;
        end
    end

    // Frame edge history, frame counter, pending seed request and operation kind
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vsync_prev <= 1'b1;
            r_frame_cnt  <= '0;
            r_seed_pend  <= 1'b0;
            r_pend_sel   <= '0;
            r_op_seed    <= 1'b0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_swap) begin
                r_frame_cnt <= '0;
            end else if ((r_state == ST_IDLE) && w_tick) begin
                r_frame_cnt <= w_frame_next[LOG_MAX_SPEED-1:0];
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
            if ((r_state != ST_IDLE) && seed_load_in) begin
                r_seed_pend <= 1'b1;
                r_pend_sel  <= seed_sel_in;
            end else if (w_start_seed) begin
                r_seed_pend <= 1'b0;
                r_pend_sel  <= r_pend_sel;
            end else begin
                r_seed_pend <= r_seed_pend;
                r_pend_sel  <= r_pend_sel;
            end
            if (w_start_seed) begin
                r_op_seed <= 1'b1;
            end else if (w_start_gen) begin
                r_op_seed <= 1'b0;
            end else begin
                r_op_seed <= r_op_seed;
            end
        end
    end

    assign gen_start_out  = r_gen_start;
    assign seed_start_out = r_seed_start;
    assign seed_sel_out   = r_seed_sel;
    assign buf_sel_out    = r_buf_sel;
    assign gen_count_out  = r_gen_count;
    assign busy_out       = r_busy;

endmodule
